// File: rtl/mw_cook_if.sv
// Microwave cook controller bus: keypad/strobe inputs, display, magnetron and status outputs.
// Latency: wires only, no storage.
// Backpressure: none; all inputs are single-cycle strobes or levels, outputs always valid.
// Signals:
//   key_valid/key_code      keypad digit strobe
//   power_set/power_level   power level load strobe
//   start/stop/clear        control strobes
//   door_closed             door interlock level (1 = closed)
//   mag_on                  magnetron enable (gated by door)
//   time_bcd                {min MSD..min LSD, sec tens, sec ones}
//   state                   IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
//   done_beep/tick_1hz      beeper enable, 1 Hz pulse while COOK or DONE
interface mw_cook_if #(
   parameter int MIN_DIGITS = 2
);
   localparam int W = 4 * (MIN_DIGITS + 2);

   logic         key_valid;
   logic [3:0]   key_code;
   logic         power_set;
   logic [3:0]   power_level;
   logic         start;
   logic         stop;
   logic         clear;
   logic         door_closed;
   logic         mag_on;
   logic [W-1:0] time_bcd;
   logic [2:0]   state;
   logic         done_beep;
   logic         tick_1hz;

   modport master (
      output key_valid, key_code, power_set, power_level, start, stop, clear, door_closed,
      input  mag_on, time_bcd, state, done_beep, tick_1hz
   );

   modport slave (
      input  key_valid, key_code, power_set, power_level, start, stop, clear, door_closed,
      output mag_on, time_bcd, state, done_beep, tick_1hz
   );
endinterface

// File: rtl/mw_cook_controller.sv
// Microwave cook controller: keypad entry, MM:SS BCD countdown, power duty cycling, done beep.
// Latency: strobes act on the next clk edge; mag_on also drops combinationally with the door.
// Backpressure: none; strobes are never stalled, lower-priority strobes in the same cycle are dropped.
// Ports: clk, rst (async active-high), bus (mw_cook_if.slave, see interface header).
module mw_cook_controller #(
   parameter int CLK_HZ       = 100,
   parameter int MIN_DIGITS   = 2,
   parameter int POWER_LEVELS = 10,
   parameter int QUICK_S      = 30,
   parameter int DONE_BEEP_S  = 3
) (
   input logic      clk,
   input logic      rst,
   mw_cook_if.slave bus
);
   localparam int W  = 4 * (MIN_DIGITS + 2);
   localparam int ND = MIN_DIGITS + 2;
   localparam int PW = $clog2(CLK_HZ);
   localparam int BW = (DONE_BEEP_S > 1) ? $clog2(DONE_BEEP_S) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [BW-1:0] BEEP_MAX  = BW'(DONE_BEEP_S - 1);
   localparam logic [3:0]    PWR_MAX   = 4'(POWER_LEVELS);
   localparam logic [3:0]    WIN_MAX   = 4'(POWER_LEVELS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_n;
   logic [W-1:0]  time_q, time_n;
   logic [3:0]    power_q, power_n;
   logic [PW-1:0] presc_q, presc_n;
   logic [3:0]    window_q, window_n;
   logic [BW-1:0] beep_q, beep_n;
   logic          mag_reg, mag_n;
   logic          tick;
   logic [W-1:0]  key_shift;

   // One-second BCD decrement; seconds tens borrows from 5, all other digits from 9.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] t);
      logic [W-1:0] r;
      logic         borrow;
      r      = t;
      borrow = 1'b1;
      for (int d = 0; d < ND; d++) begin
         if (borrow) begin
            if (t[4*d +: 4] == 4'd0) begin
               r[4*d +: 4] = (d == 1) ? 4'd5 : 4'd9;
            end else begin
               r[4*d +: 4] = t[4*d +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick      = ((state_q == S_COOK) || (state_q == S_DONE)) && (presc_q == PRESC_MAX);
   assign key_shift = {time_q[W-5:0], bus.key_code};

   always_comb begin
      state_n  = state_q;
      time_n   = time_q;
      power_n  = power_q;
      window_n = window_q;
      beep_n   = beep_q;
      presc_n  = '0;

      if (bus.clear) begin
         state_n = S_IDLE;
         time_n  = '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_SET: begin
               if (bus.stop) begin
                  // Stop while entering time cancels the entry.
                  state_n = S_IDLE;
                  time_n  = '0;
               end else if (bus.start) begin
                  if (bus.door_closed) begin
                     state_n = S_COOK;
                     if (state_q == S_IDLE) begin
                        time_n      = '0;
                        time_n[7:0] = {4'(QUICK_S / 10), 4'(QUICK_S % 10)};
                     end
                  end
               end else if (!bus.power_set && bus.key_valid && (bus.key_code <= 4'd9)) begin
                  time_n  = key_shift;
                  state_n = (key_shift != '0) ? S_SET : S_IDLE;
               end
            end
            S_COOK: begin
               // Completion wins over stop and door opening on the final tick.
               if (tick && (time_q == W'(1))) begin
                  state_n = S_DONE;
                  time_n  = '0;
               end else begin
                  if (tick) begin
                     time_n   = bcd_dec(time_q);
                     window_n = (window_q == WIN_MAX) ? 4'd0 : window_q + 4'd1;
                  end
                  if (bus.stop || !bus.door_closed) state_n = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (bus.stop) begin
                  state_n = S_IDLE;
                  time_n  = '0;
               end else if (bus.start && bus.door_closed) begin
                  state_n = S_COOK;
               end
            end
            S_DONE: begin
               if (bus.stop || bus.start || bus.key_valid) begin
                  state_n = S_IDLE;
               end else if (tick) begin
                  if (beep_q == BEEP_MAX) state_n = S_IDLE;
                  else                    beep_n  = beep_q + 1'b1;
               end
            end
            default: begin
               state_n = S_IDLE;
               time_n  = '0;
            end
         endcase

         if (bus.power_set && !bus.stop && !bus.start && (bus.power_level != 4'd0)) begin
            power_n = (bus.power_level > PWR_MAX) ? PWR_MAX : bus.power_level;
         end
      end

      // Entering COOK restarts the duty window; entering DONE restarts the beep count.
      if ((state_n == S_COOK) && (state_q != S_COOK)) window_n = 4'd0;
      if ((state_n == S_DONE) && (state_q != S_DONE)) beep_n   = '0;

      // Prescaler only runs while staying in COOK/DONE; every entry starts a fresh second.
      if (((state_n == S_COOK) || (state_n == S_DONE)) && (state_n == state_q)) begin
         presc_n = tick ? '0 : presc_q + 1'b1;
      end

      mag_n = (state_n == S_COOK) && (window_n < power_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         time_q   <= '0;
         power_q  <= PWR_MAX;
         presc_q  <= '0;
         window_q <= 4'd0;
         beep_q   <= '0;
         mag_reg  <= 1'b0;
      end else begin
         state_q  <= state_n;
         time_q   <= time_n;
         power_q  <= power_n;
         presc_q  <= presc_n;
         window_q <= window_n;
         beep_q   <= beep_n;
         mag_reg  <= mag_n;
      end
   end

   // Door gate is combinational so opening the door cuts the magnetron within the cycle.
   assign bus.mag_on    = mag_reg & bus.door_closed;
   assign bus.time_bcd  = time_q;
   assign bus.state     = state_q;
   assign bus.done_beep = (state_q == S_DONE);
   assign bus.tick_1hz  = tick;
endmodule
